// File: rtl/insn_encoder_loader.sv
// insn_encoder_loader: encodes RV32I instructions from decoded fields and
// streams them into imem through a small buffer and a back-pressured port.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start               open a load session (IDLE only)
//   i_req_vld/o_req_rdy   encode request handshake, i_req_last ends session
//   i_cls, i_alu_op, i_funct3, i_rd, i_rs1, i_rs2, i_imm  decoded fields
//   o_imem_we/i_imem_rdy  imem write handshake, o_imem_addr/o_imem_wdata
//   o_err, o_err_cnt      illegal-request pulse and saturating count
//   o_wr_cnt, o_ovf       words written, address space exhausted (sticky)
//   o_done, o_busy        session end pulse, session in progress
module insn_encoder_loader #(
    parameter int ADDR_W     = 11,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_req_vld,
    output logic              o_req_rdy,
    input  logic              i_req_last,
    input  logic [3:0]        i_cls,
    input  logic [3:0]        i_alu_op,
    input  logic [2:0]        i_funct3,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [31:0]       i_imm,
    output logic              o_imem_we,
    input  logic              i_imem_rdy,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_err,
    output logic [7:0]        o_err_cnt,
    output logic [ADDR_W:0]   o_wr_cnt,
    output logic              o_ovf,
    output logic              o_done,
    output logic              o_busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_C = '1;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [PW:0]       cnt_q;
    logic [PW:0]       cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   wr_cnt_q;
    logic [7:0]        err_cnt_q;
    logic              ovf_q;
    logic              err_q;
    logic [31:0]       mem_q [FIFO_DEPTH];

    // ALU op to funct3 / legality
    logic [2:0] af3;
    logic       alu_ok;
    logic       alu_sh;
    logic [6:0] af7;

    always_comb begin
        af3    = 3'b000;
        alu_ok = 1'b1;
        case (i_alu_op)
            4'd0, 4'd1: af3 = 3'b000;
            4'd2:       af3 = 3'b001;
            4'd3:       af3 = 3'b010;
            4'd4:       af3 = 3'b011;
            4'd5:       af3 = 3'b100;
            4'd6, 4'd7: af3 = 3'b101;
            4'd8:       af3 = 3'b110;
            4'd9:       af3 = 3'b111;
            default:    alu_ok = 1'b0;
        endcase
    end

    assign alu_sh = (i_alu_op == 4'd2) | (i_alu_op == 4'd6) |
                    (i_alu_op == 4'd7);
    assign af7 = ((i_alu_op == 4'd1) | (i_alu_op == 4'd7)) ?
                 7'h20 : 7'h00;

    // Immediate range checks: upper bits must be a pure sign extension
    logic imm_i_ok;
    logic imm_b_ok;
    logic imm_j_ok;

    assign imm_i_ok = (i_imm[31:11] == '0) | (i_imm[31:11] == '1);
    assign imm_b_ok = ((i_imm[31:12] == '0) | (i_imm[31:12] == '1)) &
                      ~i_imm[0];
    assign imm_j_ok = ((i_imm[31:20] == '0) | (i_imm[31:20] == '1)) &
                      ~i_imm[0];

    logic ld_f3_ok;
    logic st_f3_ok;
    logic br_f3_ok;

    assign ld_f3_ok = (i_funct3 != 3'b011) & (i_funct3 != 3'b110) &
                      (i_funct3 != 3'b111);
    assign st_f3_ok = (i_funct3 == 3'b000) | (i_funct3 == 3'b001) |
                      (i_funct3 == 3'b010);
    assign br_f3_ok = (i_funct3 != 3'b010) & (i_funct3 != 3'b011);

    logic [31:0] enc_word;
    logic        enc_ok;

    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b0;
        case (i_cls)
            4'd0: begin
                enc_word = {af7, i_rs2, i_rs1, af3, i_rd, OP_R};
                enc_ok   = alu_ok;
            end
            4'd1: begin
                if (alu_sh) begin
                    enc_word = {af7, i_imm[4:0], i_rs1, af3, i_rd, OP_I};
                    enc_ok   = alu_ok & (i_imm[31:5] == '0);
                end else begin
                    enc_word = {i_imm[11:0], i_rs1, af3, i_rd, OP_I};
                    enc_ok   = alu_ok & (i_alu_op != 4'd1) & imm_i_ok;
                end
            end
            4'd2: begin
                enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
                enc_ok   = ld_f3_ok & imm_i_ok;
            end
            4'd3: begin
                enc_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3,
                            i_imm[4:0], OP_STORE};
                enc_ok   = st_f3_ok & imm_i_ok;
            end
            4'd4: begin
                enc_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                            i_imm[4:1], i_imm[11], OP_BR};
                enc_ok   = br_f3_ok & imm_b_ok;
            end
            4'd5: begin
                enc_word = {i_imm[31:12], i_rd, OP_LUI};
                enc_ok   = 1'b1;
            end
            4'd6: begin
                enc_word = {i_imm[31:12], i_rd, OP_AUIPC};
                enc_ok   = 1'b1;
            end
            4'd7: begin
                enc_word = {i_imm[20], i_imm[10:1], i_imm[11],
                            i_imm[19:12], i_rd, OP_JAL};
                enc_ok   = imm_j_ok;
            end
            4'd8: begin
                enc_word = {i_imm[11:0], i_rs1, 3'b000, i_rd, OP_JALR};
                enc_ok   = (i_funct3 == 3'b000) & imm_i_ok;
            end
            default: begin
                enc_word = '0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    logic accept;
    logic push;
    logic pop;

    assign o_req_rdy = (state_q == S_RUN) & (cnt_q != DEPTH_C) & ~ovf_q;
    assign o_imem_we = (cnt_q != '0) & ~ovf_q;
    assign accept    = i_req_vld & o_req_rdy;
    assign push      = accept & enc_ok;
    assign pop       = o_imem_we & i_imem_rdy;

    always_comb begin
        cnt_d = cnt_q;
        if (push & ~pop) begin
            cnt_d = cnt_q + (PW+1)'(1);
        end else if (pop & ~push) begin
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wptr_q] <= enc_word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            addr_q    <= BASE_C;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= accept & ~enc_ok;
            if (accept & ~enc_ok & (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            cnt_q <= cnt_d;
            if (pop) begin
                rptr_q   <= rptr_q + PW'(1);
                wr_cnt_q <= wr_cnt_q + (ADDR_W+1)'(1);
                // Last word of the address space: park, never wrap
                if (addr_q == LAST_C) begin
                    ovf_q <= 1'b1;
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q   <= S_RUN;
                        addr_q    <= BASE_C;
                        wr_cnt_q  <= '0;
                        err_cnt_q <= '0;
                        ovf_q     <= 1'b0;
                        wptr_q    <= '0;
                        rptr_q    <= '0;
                        cnt_q     <= '0;
                    end
                end
                S_RUN, S_FLUSH: begin
                    // Overflow ends the session and discards what is left
                    if (ovf_q) begin
                        state_q <= S_DONE;
                        wptr_q  <= '0;
                        rptr_q  <= '0;
                        cnt_q   <= '0;
                    end else if (state_q == S_RUN) begin
                        if (accept & i_req_last) begin
                            state_q <= S_FLUSH;
                        end
                    end else if (cnt_q == '0) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = mem_q[rptr_q];
    assign o_err        = err_q;
    assign o_err_cnt    = err_cnt_q;
    assign o_wr_cnt     = wr_cnt_q;
    assign o_ovf        = ovf_q;
    assign o_done       = (state_q == S_DONE);
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_insn_encoder_loader.sv
// Directed bench for insn_encoder_loader: encodings, illegal requests,
// back-pressure, session end, overflow on a 4-word imem, mid-session reset.
module tb_insn_encoder_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, s_start, vld, last, irdy, s_irdy;
    logic [3:0]  cls, alu;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    logic        req_rdy, we, err, ovf, done, busy;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [7:0]  err_cnt;
    logic [11:0] wr_cnt;

    logic        s_req_rdy, s_we, s_err, s_ovf, s_done, s_busy;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [7:0]  s_err_cnt;
    logic [2:0]  s_wr_cnt;

    insn_encoder_loader #(.ADDR_W(11), .BASE_ADDR(0), .FIFO_DEPTH(4)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_start(start),
        .i_req_vld(vld), .o_req_rdy(req_rdy), .i_req_last(last),
        .i_cls(cls), .i_alu_op(alu), .i_funct3(f3),
        .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm),
        .o_imem_we(we), .i_imem_rdy(irdy), .o_imem_addr(addr),
        .o_imem_wdata(wdata), .o_err(err), .o_err_cnt(err_cnt),
        .o_wr_cnt(wr_cnt), .o_ovf(ovf), .o_done(done), .o_busy(busy)
    );

    insn_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0), .FIFO_DEPTH(4)) u_small (
        .i_clk(clk), .i_reset(rst), .i_start(s_start),
        .i_req_vld(vld), .o_req_rdy(s_req_rdy), .i_req_last(last),
        .i_cls(cls), .i_alu_op(alu), .i_funct3(f3),
        .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm),
        .o_imem_we(s_we), .i_imem_rdy(s_irdy), .o_imem_addr(s_addr),
        .o_imem_wdata(s_wdata), .o_err(s_err), .o_err_cnt(s_err_cnt),
        .o_wr_cnt(s_wr_cnt), .o_ovf(s_ovf), .o_done(s_done), .o_busy(s_busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_data_q[$];
    logic [31:0] exp_addr_q[$];
    int wr_seen = 0;
    int s_wr_seen = 0;
    int next_addr = 0;

    always @(posedge clk) begin
        if (!rst && we && irdy) begin
            wr_seen++;
            if (exp_data_q.size() == 0) begin
                chk("unexpected_wr", 32'(addr), 32'hFFFF_FFFF);
            end else begin
                chk("wr_addr", 32'(addr), exp_addr_q.pop_front());
                chk("wr_data", wdata, exp_data_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && s_we && s_irdy) s_wr_seen++;
    end

    function automatic logic [31:0] addi_w(input logic [4:0] d,
                                           input logic [11:0] v);
        return {v, 5'd0, 3'b000, d, 7'b0010011};
    endfunction

    // Called at a negedge; returns at a negedge with vld dropped.
    task automatic send(input bit sm, input logic [3:0] c, input logic [3:0] a,
                        input logic [2:0] f, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im, input bit lst, input bit ok,
                        input logic [31:0] exp);
        bit acc = 1'b0;
        cls = c; alu = a; f3 = f; rd = d; rs1 = s1; rs2 = s2; imm = im;
        last = lst; vld = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            #1;
            if (sm ? s_req_rdy : req_rdy) begin
                acc = 1'b1;
                if (ok && !sm) begin
                    exp_data_q.push_back(exp);
                    exp_addr_q.push_back(32'(next_addr));
                    next_addr++;
                end
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        chk("req_accept", 32'(acc), 32'd1);
        @(negedge clk);
        vld = 1'b0; last = 1'b0;
    endtask

    task automatic start_session(input bit sm);
        if (sm) s_start = 1'b1; else start = 1'b1;
        @(negedge clk);
        s_start = 1'b0; start = 1'b0;
    endtask

    task automatic wait_done(input bit sm);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (sm ? s_done : done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    logic [3:0]  il_cls [6] = '{4'd9, 4'd1, 4'd2, 4'd4, 4'd8, 4'd0};
    logic [3:0]  il_alu [6] = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd10};
    logic [2:0]  il_f3  [6] = '{3'd0, 3'd0, 3'd3, 3'd0, 3'd1, 3'd0};
    logic [31:0] il_imm [6] = '{32'd0, 32'd0, 32'd0, -32'sd3, 32'd0, 32'd0};

    int seen0;

    initial begin
        rst = 1'b1; start = 1'b0; s_start = 1'b0; vld = 1'b0; last = 1'b0;
        irdy = 1'b1; s_irdy = 1'b1;
        cls = '0; alu = '0; f3 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_rdy", 32'(req_rdy), 32'd0);
        chk("rst_flags", {28'd0, err, ovf, done, s_busy}, 32'd0);
        chk("rst_cnts", {12'd0, err_cnt, wr_cnt}, 32'd0);
        @(negedge clk);

        // Session 1: encodings and illegal requests
        next_addr = 0;
        start_session(0);
        chk("s1_busy", 32'(busy), 32'd1);
        send(0, 4'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0, 1, 32'h002081B3);
        repeat (2) @(negedge clk);
        chk("wr_cnt1", 32'(wr_cnt), 32'd1);
        send(0, 4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, -32'sd1, 0, 1, 32'hFFF00093);
        send(0, 4'd3, 4'd0, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8, 0, 1, 32'h0020A423);
        send(0, 4'd4, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, -32'sd4, 0, 1, 32'hFE000EE3);
        send(0, 4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 0, 0, 32'd0);
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_cnt1", 32'(err_cnt), 32'd1);
        @(negedge clk);
        chk("err_clear", 32'(err), 32'd0);
        send(0, 4'd0, 4'd1, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 0, 1, 32'h403100B3);
        send(0, 4'd1, 4'd7, 3'd0, 5'd1, 5'd2, 5'd0, 32'd3, 0, 1, 32'h40315093);
        send(0, 4'd5, 4'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 0, 1,
             32'h123452B7);
        send(0, 4'd2, 4'd0, 3'd4, 5'd5, 5'd6, 5'd0, -32'sd8, 0, 1,
             32'hFF834283);
        send(0, 4'd4, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd4094, 0, 1,
             32'h7E000FE3);
        for (int k = 0; k < 6; k++) begin
            send(0, il_cls[k], il_alu[k], il_f3[k], 5'd1, 5'd1, 5'd1,
                 il_imm[k], 0, 0, 32'd0);
            chk("il_err", 32'(err), 32'd1);
        end
        send(0, 4'd8, 4'd0, 3'd0, 5'd1, 5'd5, 5'd0, 32'd4, 0, 1, 32'h004280E7);
        send(0, 4'd7, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1, 1, 32'h008000EF);
        wait_done(0);
        chk("s1_sb_empty", 32'(exp_data_q.size()), 32'd0);
        chk("s1_wr_cnt", 32'(wr_cnt), 32'd11);
        chk("s1_err_cnt", 32'(err_cnt), 32'd7);
        @(negedge clk);
        chk("s1_done_pulse", 32'(done), 32'd0);
        chk("s1_busy_end", 32'(busy), 32'd0);

        // Session 2: back-pressure, order and addresses preserved
        next_addr = 0;
        irdy = 1'b0;
        start_session(0);
        chk("s2_clear", {12'd0, err_cnt, wr_cnt}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            send(0, 4'd1, 4'd0, 3'd0, 5'(k + 1), 5'd0, 5'd0, 32'(k + 10), 0, 1,
                 addi_w(5'(k + 1), 12'(k + 10)));
        end
        #1;
        chk("bp_rdy_low", 32'(req_rdy), 32'd0);
        chk("bp_we", 32'(we), 32'd1);
        repeat (5) @(negedge clk);
        chk("bp_addr_hold", 32'(addr), 32'd0);
        chk("bp_data_hold", wdata, addi_w(5'd1, 12'd10));
        irdy = 1'b1;
        for (int k = 4; k < 6; k++) begin
            send(0, 4'd1, 4'd0, 3'd0, 5'(k + 1), 5'd0, 5'd0, 32'(k + 10),
                 (k == 5), 1, addi_w(5'(k + 1), 12'(k + 10)));
        end
        wait_done(0);
        chk("s2_wr_cnt", 32'(wr_cnt), 32'd6);
        chk("s2_sb_empty", 32'(exp_data_q.size()), 32'd0);
        @(negedge clk);

        // Session 3: 4-word imem overflows
        start_session(1);
        for (int k = 0; k < 5; k++) begin
            send(1, 4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'(k), (k == 4), 0,
                 32'd0);
        end
        wait_done(1);
        chk("ovf_set", 32'(s_ovf), 32'd1);
        chk("ovf_writes", 32'(s_wr_seen), 32'd4);
        chk("ovf_wr_cnt", 32'(s_wr_cnt), 32'd4);
        chk("ovf_addr", 32'(s_addr), 32'd3);
        @(negedge clk);
        chk("ovf_idle", 32'(s_busy), 32'd0);

        // Session 4: reset mid-session
        irdy = 1'b0;
        start_session(0);
        send(0, 4'd0, 4'd0, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0, 0, 0, 32'd0);
        send(0, 4'd0, 4'd0, 3'd0, 5'd2, 5'd1, 5'd1, 32'd0, 0, 0, 32'd0);
        chk("mr_we_before", 32'(we), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        irdy = 1'b1;
        seen0 = wr_seen;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_we", 32'(we), 32'd0);
        chk("mr_rdy", 32'(req_rdy), 32'd0);
        repeat (4) @(negedge clk);
        chk("mr_no_pulse", {30'd0, done, err}, 32'd0);
        chk("mr_no_write", 32'(wr_seen - seen0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
